// File: rtl/iface_array_to_bit_ser_if.sv
// Interface I: carries the 8-bit parallel word.
// Ports: x (packed word); master drives it, slave reads it.
interface I;
  logic [7:0] x;

  modport master (output x);
  modport slave  (input  x);
endinterface

// File: rtl/iface_array_to_bit_ser.sv
// Parallel-to-serial converter: accepts an 8-bit word, emits it bit by bit.
// Ports: i_clk, i_rst (sync, high), i_valid/i_data/o_ready (word in),
//        o_bit/o_bitValid/i_ready/o_last (bit out), o_busy (shifting).
module iface_array_to_bit_ser #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_bit,
  output logic       o_bitValid,
  input  logic       i_ready,
  output logic       o_last,
  output logic       o_busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sreg_q, sreg_d;
  logic [2:0] cnt_q, cnt_d;
  logic       shifting;

  I u_I ();

  always_comb u_I.x = i_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      sreg_q  <= 8'h00;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          sreg_d  = u_I.x;
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (i_ready) begin
          if (cnt_q == 3'd7) begin
            cnt_d   = 3'd0;
            state_d = IDLE;
          end else begin
            // Shift toward the output end, zero-fill.
            if (MSB_FIRST)
              sreg_d = {sreg_q[6:0], 1'b0};
            else
              sreg_d = {1'b0, sreg_q[7:1]};
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is held, even on the very
  // first cycle when the registers have not yet been cleared.
  assign shifting   = (state_q == SHIFT) && !i_rst;
  assign o_ready    = (state_q == IDLE) && !i_rst;
  assign o_bitValid = shifting;
  assign o_busy     = shifting;
  assign o_last     = shifting && (cnt_q == 3'd7);
  assign o_bit      = !i_rst &&
                      (MSB_FIRST ? sreg_q[7] : sreg_q[0]);

endmodule

// File: doc/iface_array_to_bit_ser.md
IFACE_ARRAY_TO_BIT_SER -- requirements
Module: iface_array_to_bit_ser

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, which selects bit order: 1 = bit 7 first, 0 = bit 0 first.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port i_valid, input, 1, parallel word offered.
REQ-005 SHALL have port i_data, input, 8, parallel word.
REQ-006 SHALL have port o_ready, output, 1, word accepted when i_valid && o_ready.
REQ-007 SHALL have port o_bit, output, 1, serial data bit.
REQ-008 SHALL have port o_bitValid, output, 1, o_bit is valid.
REQ-009 SHALL have port i_ready, input, 1, downstream consumes bit when o_bitValid && i_ready.
REQ-010 SHALL have port o_last, output, 1, current bit is the 8th bit of the word.
REQ-011 SHALL have port o_busy, output, 1, a word is being shifted.
REQ-012 SHALL instantiate one instance u_I of interface I, which has packed member logic [7:0] x.
REQ-013 SHALL drive u_I.x from i_data with always_comb, full 8-bit width, and no implicit extension.
REQ-014 SHALL read the parallel word only through u_I.x; no direct use of i_data elsewhere.

Function
REQ-015 SHALL implement FSM states IDLE and SHIFT, plus an 8-bit shift register sreg and a 3-bit counter cnt.
REQ-016 In IDLE: o_ready=1, o_bitValid=0, o_busy=0, o_last=0.
REQ-017 IDLE, i_valid=1: SHALL load sreg<=u_I.x and cnt<=0, then go to SHIFT next cycle; latency from accept to first o_bitValid is 1 cycle.
REQ-018 IDLE, i_valid=0: SHALL hold state; sreg and cnt unchanged.
REQ-019 In SHIFT: o_ready=0, o_bitValid=1, o_busy=1; i_valid and i_data are ignored.
REQ-020 o_bit SHALL be sreg[7] when MSB_FIRST=1, else sreg[0]; it is combinational from sreg.
REQ-021 SHIFT, i_ready=1, cnt<7: SHALL shift sreg by one toward the output end, zero-fill, and set cnt<=cnt+1.
REQ-022 SHIFT, i_ready=0: SHALL hold sreg, cnt and o_bit stable; backpressure has unlimited duration.
REQ-023 o_last SHALL be 1 exactly when state=SHIFT and cnt=7.
REQ-024 SHIFT, cnt=7, i_ready=1: SHALL go to IDLE, with cnt wrapping to 0; no word is accepted in that same cycle.
REQ-025 Minimum period per word SHALL be 9 cycles: 1 accept cycle plus 8 bit cycles.
REQ-026 u_I.x changing during SHIFT SHALL have no effect on the bits being shifted.

Reset
REQ-027 While i_rst=1, on each clock: state<=IDLE, sreg<=8'h00, cnt<=0.
REQ-028 While i_rst=1: o_ready=0, o_bitValid=0, o_last=0, o_busy=0; o_bit=0.
REQ-029 i_rst during SHIFT SHALL abort the word with no further bits emitted; the first cycle after reset deasserts is IDLE with o_ready=1.
REQ-030 i_valid SHALL be ignored on any cycle where i_rst=1.

Verification
REQ-031 MSB_FIRST=1, i_data=8'hA5, i_valid for 1 cycle, i_ready=1 -> o_bit sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles; o_last only on the 8th; o_ready=1 again on the 9th.
REQ-032 MSB_FIRST=0, i_data=8'h01 -> o_bit sequence 1,0,0,0,0,0,0,0, with o_last on the final 0.
REQ-033 8'hC3 with i_ready toggling 1,0,1,0,... -> same bit order as with i_ready=1; o_bit stable while i_ready=0; 16 cycles from first o_bitValid to return to IDLE.
REQ-034 i_data changed to 8'hFF and i_valid held high during SHIFT of 8'h00 -> all 8 bits are 0; 8'hFF is accepted only once the block is back in IDLE.
REQ-035 i_rst pulsed after 3 bits of 8'hF0 -> o_bitValid=0 the next cycle, then IDLE with o_ready=1; a following word 8'h81 serializes correctly from bit 0 of the count.
REQ-036 i_valid=1 with i_rst=1 -> no load; sreg stays 8'h00 and the state remains IDLE.
